// File: rtl/display_arbiter.sv
// Round-robin owner of the two-digit seven-segment display, shared by three pattern sources.
// Every hand-over passes through a blanking gap; ownership has minimum and maximum hold times.
module display_arbiter #(
  parameter int unsigned g_MIN_HOLD = 25000000/10,
  parameter int unsigned g_MAX_HOLD = 25000000*2,
  parameter int unsigned g_BLANK    = 25000000/50
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [2:0]  i_Req,
  input  logic [13:0] i_Seg_0,
  input  logic [13:0] i_Seg_1,
  input  logic [13:0] i_Seg_2,
  output logic [2:0]  o_Grant,
  output logic [13:0] o_Segments,
  output logic        o_Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    OWN   = 2'd2
  } state_t;

  localparam logic [31:0] BLANK_END = 32'(g_BLANK - 1);
  localparam logic [31:0] MIN_END   = 32'(g_MIN_HOLD - 1);
  localparam logic [31:0] MAX_END   = 32'(g_MAX_HOLD - 1);

  state_t      state, state_nxt;
  logic [31:0] r_Count, count_nxt;
  logic [1:0]  r_Next, next_nxt;
  logic [1:0]  r_Last, last_nxt;
  logic [2:0]  grant_nxt;
  logic [13:0] seg_nxt;
  logic [13:0] owner_seg;
  logic        owner_req;
  logic        other_req;

  function automatic logic [1:0] idx_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'(3'b001 << idx);
  endfunction

  // Scan starts just after 'last', so the previous owner ranks last.
  function automatic logic [1:0] pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    idx   = idx_inc(last);
    res   = idx;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = idx_inc(idx);
    end
    return res;
  endfunction

  always_comb begin
    owner_seg = '0;
    case (r_Next)
      2'd0:    owner_seg = i_Seg_0;
      2'd1:    owner_seg = i_Seg_1;
      2'd2:    owner_seg = i_Seg_2;
      default: owner_seg = '0;
    endcase
  end

  assign owner_req = |(i_Req & onehot(r_Next));
  assign other_req = |(i_Req & ~onehot(r_Next));

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt = state;
    count_nxt = r_Count;
    next_nxt  = r_Next;
    last_nxt  = r_Last;
    grant_nxt = o_Grant;
    seg_nxt   = o_Segments;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        seg_nxt   = '0;
        if (|i_Req) begin
          next_nxt  = pick(i_Req, r_Last);
          count_nxt = '0;
          state_nxt = BLANK;
        end
      end
      BLANK: begin
        grant_nxt = '0;
        seg_nxt   = '0;
        if (!owner_req) begin
          state_nxt = IDLE;
        end else if (r_Count == BLANK_END) begin
          state_nxt = OWN;
          grant_nxt = onehot(r_Next);
          seg_nxt   = owner_seg;
          count_nxt = '0;
        end else begin
          count_nxt = r_Count + 32'd1;
        end
      end
      OWN: begin
        seg_nxt = owner_seg;
        if (r_Count != MAX_END) count_nxt = r_Count + 32'd1;
        if (r_Count >= MIN_END && (!owner_req || (other_req && r_Count == MAX_END))) begin
          last_nxt  = r_Next;
          grant_nxt = '0;
          seg_nxt   = '0;
          if (|i_Req) begin
            state_nxt = BLANK;
            next_nxt  = pick(i_Req, r_Next);
            count_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        seg_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state      <= IDLE;
      r_Count    <= '0;
      r_Next     <= 2'd0;
      r_Last     <= 2'd2;
      o_Grant    <= '0;
      o_Segments <= '0;
    end else begin
      state      <= state_nxt;
      r_Count    <= count_nxt;
      r_Next     <= next_nxt;
      r_Last     <= last_nxt;
      o_Grant    <= grant_nxt;
      o_Segments <= seg_nxt;
    end
  end

  assign o_Busy = (state != IDLE);

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed scenarios plus randomized traffic
// compared against an owner/candidate reference model.
module tb_display_arbiter;

  localparam int MIN_HOLD = 4;
  localparam int MAX_HOLD = 10;
  localparam int BLANK    = 2;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic [2:0]  i_Req;
  logic [13:0] i_Seg_0, i_Seg_1, i_Seg_2;
  logic [2:0]  o_Grant;
  logic [13:0] o_Segments;
  logic        o_Busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the display, who is waiting out the blank gap, and for how long.
  int          m_owner, m_cand, m_blank, m_held, m_last;
  logic [2:0]  exp_grant;
  logic [13:0] exp_seg;

  display_arbiter #(
    .g_MIN_HOLD(MIN_HOLD),
    .g_MAX_HOLD(MAX_HOLD),
    .g_BLANK   (BLANK)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .i_Req     (i_Req),
    .i_Seg_0   (i_Seg_0),
    .i_Seg_1   (i_Seg_1),
    .i_Seg_2   (i_Seg_2),
    .o_Grant   (o_Grant),
    .o_Segments(o_Segments),
    .o_Busy    (o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int pick(input logic [2:0] req, input int last);
    for (int off = 1; off <= 3; off++) begin
      int idx;
      idx = (last + off) % 3;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [13:0] seg_in(input int src);
    case (src)
      0:       return i_Seg_0;
      1:       return i_Seg_1;
      default: return i_Seg_2;
    endcase
  endfunction

  function automatic logic exp_busy();
    return (m_owner >= 0) || (m_cand >= 0);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cand = -1; m_blank = 0; m_held = 0; m_last = 2;
    exp_grant = '0; exp_seg = '0;
  endtask

  // One clock edge of the model, using the inputs the DUT sees at that edge.
  task automatic model_edge();
    int p;
    if (m_owner >= 0) begin
      bit others;
      m_held++;
      others = |(i_Req & ~(3'b001 << m_owner));
      if (m_held >= MIN_HOLD && (!i_Req[m_owner] || (others && m_held >= MAX_HOLD))) begin
        m_last = m_owner; m_owner = -1;
        exp_grant = '0; exp_seg = '0;
        p = pick(i_Req, m_last);
        if (p >= 0) begin m_cand = p; m_blank = 0; end
      end else begin
        exp_seg = seg_in(m_owner);
      end
    end else if (m_cand >= 0) begin
      if (!i_Req[m_cand]) begin
        m_cand = -1;
      end else begin
        m_blank++;
        if (m_blank == BLANK) begin
          m_owner = m_cand; m_cand = -1; m_held = 0;
          exp_grant = 3'(3'b001 << m_owner);
          exp_seg = seg_in(m_owner);
        end
      end
    end else begin
      p = pick(i_Req, m_last);
      if (p >= 0) begin m_cand = p; m_blank = 0; end
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    model_edge();
    @(negedge i_Clk);
  endtask

  task automatic do_reset();
    i_Reset = 1'b1;
    i_Req   = '0;
    @(negedge i_Clk);
    @(negedge i_Clk);
    model_reset();
    i_Reset = 1'b0;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    i_Req   = 3'b111;
    i_Seg_0 = 14'h3FFF; i_Seg_1 = 14'h3FFF; i_Seg_2 = 14'h3FFF;
    repeat (3) @(negedge i_Clk);
    n_tests++;
    if (o_Grant !== 3'b000 || o_Segments !== 14'h0 || o_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b seg=%h busy=%b, required 000/0000/0", o_Grant, o_Segments, o_Busy);
    end
  endtask

  task automatic test_single_owner();
    int bad;
    do_reset();
    i_Req = 3'b010; i_Seg_1 = 14'h1ABC;
    i_Seg_0 = 14'($urandom); i_Seg_2 = 14'($urandom);
    step(); step();
    n_tests++;
    if (o_Grant !== 3'b000 || o_Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: grant=%b busy=%b after 2 edges, required 000/1", o_Grant, o_Busy);
    end
    step();
    n_tests++;
    if (o_Grant !== 3'b010 || o_Segments !== 14'h1ABC) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b seg=%h, required 010/1abc", o_Grant, o_Segments);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      i_Seg_0 = 14'($urandom); i_Seg_2 = 14'($urandom);
      step();
      if (o_Grant !== 3'b010 || o_Segments !== 14'h1ABC) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL single_no_preempt: %0d of 100 cycles lost grant, required 0", bad);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] rv[$];
    int         rl[$];
    logic [2:0] exp_v[8] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    int         exp_l[7] = '{2, 10, 2, 10, 2, 10, 2};
    do_reset();
    i_Req = 3'b111;
    i_Seg_0 = 14'h0111; i_Seg_1 = 14'h0222; i_Seg_2 = 14'h0333;
    for (int i = 0; i < 60; i++) begin
      step();
      if (rv.size() == 0 || rv[rv.size()-1] !== o_Grant) begin
        rv.push_back(o_Grant);
        rl.push_back(1);
      end else begin
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
      end
      n_tests++;
      if (o_Grant !== exp_grant || o_Segments !== exp_seg) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: grant=%b seg=%h, required %b/%h", i, o_Grant, o_Segments, exp_grant, exp_seg);
      end
    end
    n_tests++;
    if (rv.size() < 8) begin
      n_fail++;
      $display("FAIL rr_runs: %0d grant runs seen, required at least 8", rv.size());
    end else begin
      for (int r = 0; r < 8; r++) begin
        n_tests++;
        if (rv[r] !== exp_v[r] || (r < 7 && rl[r] != exp_l[r])) begin
          n_fail++;
          $display("FAIL rr_run%0d: grant=%b len=%0d, required %b len=%0d",
                   r, rv[r], rl[r], exp_v[r], (r < 7) ? exp_l[r] : rl[r]);
        end
      end
    end
  endtask

  task automatic test_pulse();
    int wait_cnt, len;
    do_reset();
    i_Req = 3'b001; i_Seg_0 = 14'h2A55;
    wait_cnt = 0;
    while (o_Grant === 3'b000 && wait_cnt < 10) begin step(); wait_cnt++; end
    n_tests++;
    if (o_Grant !== 3'b001) begin
      n_fail++;
      $display("FAIL pulse_grant: grant=%b after %0d edges, required 001", o_Grant, wait_cnt);
    end
    i_Req = 3'b000;
    len = 1;
    while (o_Grant === 3'b001 && len < 20) begin
      step();
      if (o_Grant === 3'b001) len++;
    end
    n_tests++;
    if (len != MIN_HOLD) begin
      n_fail++;
      $display("FAIL pulse_hold: grant held %0d cycles, required %0d", len, MIN_HOLD);
    end
    n_tests++;
    if (o_Busy !== 1'b0 || o_Grant !== 3'b000 || o_Segments !== 14'h0) begin
      n_fail++;
      $display("FAIL pulse_idle: busy=%b grant=%b seg=%h, required 0/000/0000", o_Busy, o_Grant, o_Segments);
    end
  endtask

  task automatic test_drop_in_blank();
    int bad;
    do_reset();
    i_Req = 3'b010;
    step();
    n_tests++;
    if (o_Busy !== 1'b1 || o_Grant !== 3'b000) begin
      n_fail++;
      $display("FAIL blank_enter: busy=%b grant=%b, required 1/000", o_Busy, o_Grant);
    end
    i_Req = 3'b000;
    step();
    n_tests++;
    if (o_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL blank_drop_idle: busy=%b, required 0", o_Busy);
    end
    bad = 0;
    repeat (6) begin step(); if (o_Grant !== 3'b000) bad++; end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL blank_drop_grant: %0d cycles with grant, required 0", bad);
    end
  endtask

  task automatic test_early_drop();
    int wait_cnt, bad;
    do_reset();
    i_Req = 3'b101; i_Seg_0 = 14'h1111; i_Seg_2 = 14'h2222; i_Seg_1 = 14'h0F0F;
    wait_cnt = 0;
    while (o_Grant === 3'b000 && wait_cnt < 10) begin step(); wait_cnt++; end
    n_tests++;
    if (o_Grant !== 3'b001) begin
      n_fail++;
      $display("FAIL drop_first_owner: grant=%b, required 001", o_Grant);
    end
    bad = 0;
    repeat (5) begin step(); if (o_Grant !== 3'b001) bad++; end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL drop_hold: %0d cycles without grant, required 0", bad);
    end
    i_Req = 3'b100;
    step();
    n_tests++;
    if (o_Grant !== 3'b000 || o_Segments !== 14'h0) begin
      n_fail++;
      $display("FAIL drop_release: grant=%b seg=%h, required 000/0000", o_Grant, o_Segments);
    end
    step();
    n_tests++;
    if (o_Grant !== 3'b000 || o_Segments !== 14'h0) begin
      n_fail++;
      $display("FAIL drop_gap: grant=%b seg=%h, required 000/0000", o_Grant, o_Segments);
    end
    step();
    n_tests++;
    if (o_Grant !== 3'b100 || o_Segments !== 14'h2222) begin
      n_fail++;
      $display("FAIL drop_next_owner: grant=%b seg=%h, required 100/2222", o_Grant, o_Segments);
    end
  endtask

  task automatic test_async_reset();
    int wait_cnt;
    do_reset();
    i_Req = 3'b001; i_Seg_0 = 14'h3C3C;
    wait_cnt = 0;
    while (o_Grant === 3'b000 && wait_cnt < 10) begin step(); wait_cnt++; end
    step(); step();
    n_tests++;
    if (o_Grant !== 3'b001 || o_Segments !== 14'h3C3C) begin
      n_fail++;
      $display("FAIL areset_own: grant=%b seg=%h, required 001/3c3c", o_Grant, o_Segments);
    end
    #2;
    i_Reset = 1'b1;
    #1;
    n_tests++;
    if (o_Grant !== 3'b000 || o_Segments !== 14'h0 || o_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: grant=%b seg=%h busy=%b, required 000/0000/0", o_Grant, o_Segments, o_Busy);
    end
    @(negedge i_Clk);
    @(negedge i_Clk);
    model_reset();
    i_Reset = 1'b0;
    i_Req = 3'b001;
    step(); step();
    n_tests++;
    if (o_Grant !== 3'b000) begin
      n_fail++;
      $display("FAIL areset_latency: grant=%b after 2 edges, required 000", o_Grant);
    end
    step();
    n_tests++;
    if (o_Grant !== 3'b001) begin
      n_fail++;
      $display("FAIL areset_regrant: grant=%b, required 001", o_Grant);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 6) == 0) i_Req = 3'($urandom_range(0, 7));
      i_Seg_0 = 14'($urandom); i_Seg_1 = 14'($urandom); i_Seg_2 = 14'($urandom);
      step();
      n_tests++;
      if (o_Grant !== exp_grant || o_Segments !== exp_seg || o_Busy !== exp_busy()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: grant=%b seg=%h busy=%b, required %b/%h/%b",
                 i, o_Grant, o_Segments, o_Busy, exp_grant, exp_seg, exp_busy());
      end
    end
  endtask

  initial begin
    i_Reset = 1'b1;
    i_Req   = '0;
    i_Seg_0 = '0; i_Seg_1 = '0; i_Seg_2 = '0;
    model_reset();
    test_reset();
    test_single_owner();
    test_round_robin();
    test_pulse();
    test_drop_in_blank();
    test_early_drop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
